// File: rtl/alu_issue_stage.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_issue_stage: valid/ready sequencing stage around a 32-bit ALU.        |
// | Optional sticky overflow flag: define ALU_STAGE_STICKY_EN.                 |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module alu_issue_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_A,
  input  logic [DATA_WIDTH-1:0] in_B,
  input  logic [OP_WIDTH-1:0]   in_op,
  output logic [DATA_WIDTH-1:0] alu_A,
  output logic [DATA_WIDTH-1:0] alu_B,
  output logic [OP_WIDTH-1:0]   alu_op,
  input  logic [DATA_WIDTH-1:0] alu_Result,
  input  logic                  alu_Overflow,
  input  logic                  alu_CarryOut,
  input  logic                  alu_Zero,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_result,
  output logic [3:0]            out_flags,
`ifdef ALU_STAGE_STICKY_EN
  input  logic                  sticky_clr,
  output logic                  sticky_ovf,
`endif
  output logic [31:0]           op_count
);

  localparam logic [OP_WIDTH-1:0] OP_AND = OP_WIDTH'(3'b000);
  localparam logic [OP_WIDTH-1:0] OP_OR  = OP_WIDTH'(3'b001);
  localparam logic [OP_WIDTH-1:0] OP_ADD = OP_WIDTH'(3'b010);
  localparam logic [OP_WIDTH-1:0] OP_SUB = OP_WIDTH'(3'b110);
  localparam logic [OP_WIDTH-1:0] OP_SLT = OP_WIDTH'(3'b111);
  localparam logic [3:0]          ILLEGAL_FLAGS = 4'b1001;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] a_q, a_d;
  logic [DATA_WIDTH-1:0] b_q, b_d;
  logic [OP_WIDTH-1:0]   op_q, op_d;
  logic                  ill_q, ill_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic [3:0]            flags_q, flags_d;
  logic [31:0]           count_q, count_d;

  logic op_legal;
  logic accept;
  logic out_hs;

  assign op_legal = (in_op == OP_AND) || (in_op == OP_OR) || (in_op == OP_ADD) ||
                    (in_op == OP_SUB) || (in_op == OP_SLT);

  // rst_n gates in_ready so upstream never sees a handshake while in reset.
  assign in_ready = rst_n & ((state_q == S_IDLE) | ((state_q == S_DONE) & out_ready));
  assign accept   = in_valid & in_ready;
  assign out_hs   = valid_q & out_ready;

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    ill_d    = ill_q;
    valid_d  = valid_q;
    result_d = result_q;
    flags_d  = flags_q;
    count_d  = count_q;

    case (state_q)
      S_IDLE: ;
      S_EXEC: begin
        result_d = ill_q ? '0 : alu_Result;
        flags_d  = ill_q ? ILLEGAL_FLAGS : {1'b0, alu_Overflow, alu_CarryOut, alu_Zero};
        valid_d  = 1'b1;
        state_d  = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          count_d = count_q + 32'd1;
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Illegal encodings present AND to the ALU; the result is overridden in EXEC.
    if (accept) begin
      a_d     = in_A;
      b_d     = in_B;
      op_d    = op_legal ? in_op : OP_AND;
      ill_d   = ~op_legal;
      state_d = S_EXEC;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      ill_q    <= 1'b0;
      valid_q  <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      ill_q    <= ill_d;
      valid_q  <= valid_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      count_q  <= count_d;
    end
  end

`ifdef ALU_STAGE_STICKY_EN
  logic sticky_q, sticky_d;

  // A set from an overflowing handshake beats a simultaneous clear.
  always_comb begin
    sticky_d = (out_hs & flags_q[2]) | (sticky_q & ~sticky_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign sticky_ovf = sticky_q;
`else
  logic unused_hs;
  assign unused_hs = out_hs;
`endif

  assign alu_A      = a_q;
  assign alu_B      = b_q;
  assign alu_op     = op_q;
  assign out_valid  = valid_q;
  assign out_result = result_q;
  assign out_flags  = flags_q;
  assign op_count   = count_q;

endmodule
`default_nettype wire
